sentence_arbiter: RTL and testbench
===================================

Name: sentence_arbiter

Overview:
Shares one downstream begin/end keyword-checker datapath between two character-stream requesters. Grants one requester per sentence with round-robin fairness. Before each sentence it clears the checker, then forwards that sentence's characters. After the last character it samples the checker's verdict and returns it to the granted requester.

Parameters:
MAX_LEN, 64, maximum characters per sentence; the sentence is aborted when this count is reached without a last marker
CNT_W, 7, character counter width; must hold MAX_LEN
IDLE_TO, 16, stall cycles before abort (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has a character
req0_char  in  8  requester 0 ASCII character
req0_last  in  1  character is the last of the sentence
req0_ready  out  1  requester 0 character accepted this cycle when valid
req1_valid, req1_char, req1_last, req1_ready  same as requester 0, for requester 1
chk_clr  out  1  one-cycle clear pulse to the checker
chk_en  out  1  chk_char is valid this cycle
chk_char  out  8  character to the checker
chk_result  in  1  checker verdict; registered in the checker, valid the cycle after chk_en
grant  out  2  one-hot current owner; 00 when idle
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse; verdict available
done_id  out  1  requester served
done_result  out  1  verdict; 1 = balanced, 0 = unbalanced or aborted
overflow  out  1  qualifies done; sentence aborted at MAX_LEN
timeout  out  1  qualifies done; sentence aborted by stall (tied 0 without the optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; priority pointer favours requester 0; counters 0. A reset mid-sentence abandons the sentence and produces no done pulse.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, REPORT.
- IDLE: if any reqN_valid is high, choose the owner and go to CLEAR. When both are valid, the pointer decides; when one is valid, that one is chosen. The choice is latched into grant in the same transition.
- CLEAR: chk_clr = 1 for exactly one cycle, counter is reset to 0, then go to STREAM.
- STREAM: ready of the owner = 1; ready of the non-owner = 0 at all times.
  - On valid & ready: the next cycle has chk_en = 1 and chk_char = that character. All characters, including spaces, pass unmodified. The counter increments.
  - chk_char holds its value while chk_en = 0.
  - Leave for DRAIN when the accepted character has last = 1, or when the counter reaches MAX_LEN. In the MAX_LEN case, set the overflow flag.
  - If last = 1 arrives on the same character that reaches MAX_LEN, last takes precedence and no overflow is raised.
  - If the owner deasserts valid, remain in STREAM with ready high.
- DRAIN: one cycle. chk_en carries the final character; ready = 0.
- REPORT: one cycle.
  - done = 1; done_id = owner; overflow and timeout reflect the aborted cause.
  - done_result = chk_result, forced to 0 if overflow or timeout is set.
  - The pointer moves to favour the other requester; grant clears; the next state is IDLE.
- Latency:
  - Valid seen in IDLE at cycle T: chk_clr at T+1; ready first high at T+2.
  - Last character accepted at cycle L: chk_en at L+1, done at L+2.
  - Minimum turnaround between sentences is 1 IDLE cycle.
- A single-character sentence (last on the first character) is legal.
- Empty sentences are impossible.

Optional Feature:
SENT_IDLE_TIMEOUT_EN
- Defined: a stall counter in STREAM counts consecutive cycles with no handshake and resets on every handshake. When it reaches IDLE_TO, set the timeout flag and go to DRAIN; chk_en stays 0 in DRAIN. REPORT then gives done_result = 0 and timeout = 1.
- Not defined: there is no stall counter; STREAM waits indefinitely; the timeout port is tied to 0.

Test Plan:
- Requester 0 only sends "begin end" with last on 'd'; checker model returns 1 → chk_clr one cycle after valid; 9 chk_en pulses; done = 1, done_id = 0, done_result = 1, overflow = 0.
- Both requesters valid in IDLE after reset → requester 0 served first, then requester 1. Both valid again → requester 0 served again, because the pointer moves after each REPORT. req1_ready stays 0 throughout requester 0's sentence.
- Requester 1 sends "end begin" and the checker returns 0 → done_id = 1, done_result = 0. A valid gap of 5 cycles mid-sentence is tolerated with no abort.
- MAX_LEN = 4: requester 0 sends "abcdef" with no last → exactly 4 characters accepted, overflow = 1, done_result = 0. Repeat with last on the 4th character → overflow = 0.
- Assert reset during STREAM after 3 characters → all outputs 0 immediately; no done pulse; the next sentence starts with chk_clr.
- With SENT_IDLE_TIMEOUT_EN defined and IDLE_TO = 16: the owner stalls 16 cycles → timeout = 1, done_result = 0. A stall of 15 cycles produces no timeout.

Source files
------------

// File: rtl/sentence_arbiter.sv
// sentence_arbiter: round-robin sharing of one begin/end checker between two sentence requesters
// Optional feature macro: SENT_IDLE_TIMEOUT_EN adds a stall timeout of IDLE_TO cycles.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   reqN_valid/char/last/ready    requester N character stream (N = 0, 1)
//   chk_clr, chk_en, chk_char     clear pulse and character strobe to the checker
//   chk_result                    checker verdict, valid the cycle after chk_en
//   grant, busy                   one-hot owner (00 when idle), not-idle flag
//   done, done_id, done_result    verdict pulse, requester served, verdict
//   overflow, timeout             abort causes qualifying done
module sentence_arbiter #(
    parameter int MAX_LEN = 64,
    parameter int CNT_W = 7
`ifdef SENT_IDLE_TIMEOUT_EN
    , parameter int IDLE_TO = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_char,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_char,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       chk_clr,
    output logic       chk_en,
    output logic [7:0] chk_char,
    input  logic       chk_result,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic       done_result,
    output logic       overflow,
    output logic       timeout
);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, REPORT} state_t;
    state_t state;
    logic ptr, owner, ovf_r, pick, hs, in_last;
    logic [7:0] in_char;
    logic [CNT_W-1:0] cnt;
`ifdef SENT_IDLE_TIMEOUT_EN
    localparam int SW = $clog2(IDLE_TO + 1);
    logic [SW-1:0] stall;
    logic to_r;
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        // ptr = 1 favours requester 1 when both ask at once
        pick = (req0_valid && req1_valid) ? ptr : req1_valid;
        in_char = owner ? req1_char : req0_char;
        in_last = owner ? req1_last : req0_last;
        req0_ready = state == STREAM && !owner;
        req1_ready = state == STREAM && owner;
        hs = owner ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        // verdict arrives combinationally in the REPORT cycle; aborts force it low
        done_result = done && chk_result && !overflow && !timeout;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr <= 1'b0;
            owner <= 1'b0;
            cnt <= '0;
            ovf_r <= 1'b0;
            grant <= 2'b00;
            busy <= 1'b0;
            chk_clr <= 1'b0;
            chk_en <= 1'b0;
            chk_char <= 8'h00;
            done <= 1'b0;
            done_id <= 1'b0;
            overflow <= 1'b0;
`ifdef SENT_IDLE_TIMEOUT_EN
            timeout <= 1'b0;
            stall <= '0;
            to_r <= 1'b0;
`endif
        end else begin
            chk_clr <= 1'b0;
            chk_en <= 1'b0;
            done <= 1'b0;
            overflow <= 1'b0;
`ifdef SENT_IDLE_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: if (req0_valid || req1_valid) begin
                    owner <= pick;
                    grant <= pick ? 2'b10 : 2'b01;
                    busy <= 1'b1;
                    chk_clr <= 1'b1;
                    state <= CLEAR;
                end
                CLEAR: begin
                    cnt <= '0;
                    ovf_r <= 1'b0;
`ifdef SENT_IDLE_TIMEOUT_EN
                    stall <= '0;
                    to_r <= 1'b0;
`endif
                    state <= STREAM;
                end
                STREAM: if (hs) begin
                    chk_en <= 1'b1;
                    chk_char <= in_char;
                    cnt <= cnt + 1'b1;
`ifdef SENT_IDLE_TIMEOUT_EN
                    stall <= '0;
`endif
                    // last wins over reaching MAX_LEN on the same character
                    if (in_last) state <= DRAIN;
                    else if (cnt == CNT_W'(MAX_LEN - 1)) begin
                        ovf_r <= 1'b1;
                        state <= DRAIN;
                    end
                end
`ifdef SENT_IDLE_TIMEOUT_EN
                else if (stall == SW'(IDLE_TO - 1)) begin
                    to_r <= 1'b1;
                    state <= DRAIN;
                end else stall <= stall + 1'b1;
`endif
                DRAIN: begin
                    done <= 1'b1;
                    done_id <= owner;
                    overflow <= ovf_r;
`ifdef SENT_IDLE_TIMEOUT_EN
                    timeout <= to_r;
`endif
                    state <= REPORT;
                end
                REPORT: begin
                    ptr <= ~owner;
                    grant <= 2'b00;
                    busy <= 1'b0;
                    done_id <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sentence_arbiter.sv
// tb_sentence_arbiter: randomized and directed checks of sentence_arbiter against a sentence-level model
module tb_sentence_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
    logic [7:0] req0_char = 8'h00, req1_char = 8'h00;
    logic req0_ready, req1_ready, chk_clr, chk_en, chk_result = 1'b0;
    logic [7:0] chk_char;
    logic [1:0] grant;
    logic busy, done, done_id, done_result, overflow, timeout;

    sentence_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_char(req0_char), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_char(req1_char), .req1_last(req1_last), .req1_ready(req1_ready),
        .chk_clr(chk_clr), .chk_en(chk_en), .chk_char(chk_char), .chk_result(chk_result),
        .grant(grant), .busy(busy), .done(done), .done_id(done_id), .done_result(done_result),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        logic res, ovf, to;
        int lat;
        string fwd;
    } rec_t;

    int tests = 0, fails = 0;
    int cyc = 0, clr_cnt = 0, clr_cyc = 0, en_cnt = 0, ready_cyc = 0, viol = 0;
    bit rdy_seen = 0;
    int hs_cnt[2] = '{0, 0};
    int hs_cyc[2] = '{0, 0};
    string chk_str = "";
    rec_t dq[$];

    // balanced when every "end" closes an open "begin" and none remain open
    function automatic bit bal(input string s);
        int d = 0;
        bit ok = 1;
        string w = "";
        for (int i = 0; i <= s.len(); i++) begin
            byte c = (i < s.len()) ? s[i] : 8'h20;
            if (c == 8'h20) begin
                if (w == "begin") d++;
                else if (w == "end") begin
                    d--;
                    if (d < 0) ok = 0;
                end
                w = "";
            end else w = $sformatf("%s%c", w, c);
        end
        return ok && d == 0;
    endfunction

    function automatic string rand_sentence();
        string s = "", w;
        int n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: w = "begin";
                1: w = "end";
                2: w = "x";
                default: w = "ab";
            endcase
            s = (s == "") ? w : {s, " ", w};
        end
        return s;
    endfunction

    // external registered checker: accumulates characters since the last clear
    always @(posedge clk) begin
        chk_str <= chk_clr ? "" : chk_en ? $sformatf("%s%c", chk_str, chk_char) : chk_str;
        chk_result <= bal(chk_clr ? "" : chk_en ? $sformatf("%s%c", chk_str, chk_char) : chk_str);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_clr) begin
            clr_cnt <= clr_cnt + 1;
            clr_cyc <= cyc;
            rdy_seen <= 1'b0;
        end
        if (chk_en) en_cnt <= en_cnt + 1;
        if ((req0_ready || req1_ready) && !rdy_seen && !chk_clr) begin
            rdy_seen <= 1'b1;
            ready_cyc <= cyc;
        end
        if (req0_valid && req0_ready) begin
            hs_cnt[0] <= hs_cnt[0] + 1;
            hs_cyc[0] <= cyc;
        end
        if (req1_valid && req1_ready) begin
            hs_cnt[1] <= hs_cnt[1] + 1;
            hs_cyc[1] <= cyc;
        end
        if ((req0_ready && req1_ready) || (req0_ready && !grant[0]) || (req1_ready && !grant[1]))
            viol <= viol + 1;
        if (done) dq.push_back('{int'(done_id), done_result, overflow, timeout, cyc - hs_cyc[done_id], chk_str});
    end

    task automatic drv(input int id, input logic v, input logic [7:0] c, input logic l);
        if (id == 0) begin
            req0_valid = v; req0_char = c; req0_last = l;
        end else begin
            req1_valid = v; req1_char = c; req1_last = l;
        end
    endtask

    task automatic send(input int id, input string s, input bit lastf, input int gap_at, input int gap_len, input int hold);
        bit acc;
        int w;
        for (int i = 0; i < s.len(); i++) begin
            if (i == gap_at) begin
                drv(id, 1'b0, 8'h00, 1'b0);
                repeat (gap_len) @(posedge clk);
                #1;
            end
            drv(id, 1'b1, s[i], lastf && i == s.len() - 1);
            acc = 0;
            w = 0;
            while (!acc) begin
                @(negedge clk);
                acc = (id == 0) ? req0_ready : req1_ready;
                @(posedge clk);
                #1;
                if (!acc && ++w > 500) begin
                    tests++; fails++;
                    $display("FAIL send_wait id=%0d char=%0d: ready not seen, required within 500 cycles", id, i);
                    drv(id, 1'b0, 8'h00, 1'b0);
                    return;
                end
            end
        end
        if (hold > 0) begin
            drv(id, 1'b1, 8'h5A, 1'b0);
            repeat (hold) @(posedge clk);
            #1;
        end
        drv(id, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_done(input int n, output bit got);
        int w = 0;
        while (dq.size() < n && w < 2000) begin
            @(posedge clk);
            w++;
        end
        #1;
        got = dq.size() >= n;
    endtask

    task automatic idle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({req0_ready, req1_ready, chk_clr, chk_en, chk_char, grant, busy, done, done_id, done_result, overflow, timeout} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0", {req0_ready, req1_ready, chk_clr, chk_en, chk_char, grant, busy, done, done_id, done_result, overflow, timeout});
        end
        reset = 1'b0;
        idle();
        tests++;
        if (busy !== 1'b0 || grant !== 2'b00 || dq.size() != 0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b grant=%b dones=%0d required 0 00 0", busy, grant, dq.size());
        end
    endtask

    task automatic test_round_robin();
        rec_t r;
        bit got;
        int v0 = viol;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                send(0, "end end", 1, -1, 0, 0);
                wait_done(1, got);
                if (got) void'(dq.pop_front());
                idle();
            end
            fork
                send(0, "begin begin end end", 1, -1, 0, 0);
                send(1, "end", 1, -1, 0, 0);
            join
            wait_done(2, got);
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL rr_done round=%0d: got %0d dones required 2", k, dq.size());
            end else for (int j = 0; j < 2; j++) begin
                int eid = (k == 2) ? 1 - j : j;
                r = dq.pop_front();
                tests++;
                if ({r.id[0], r.res, r.ovf, r.to} !== {eid[0], eid == 0, 2'b00}) begin
                    fails++;
                    $display("FAIL rr_order round=%0d slot=%0d: id/res/ovf/to=%b%b%b%b required %0d%0d00", k, j, r.id[0], r.res, r.ovf, r.to, eid, eid == 0);
                end
            end
            idle();
        end
        tests++;
        if (viol != v0) begin
            fails++;
            $display("FAIL rr_ready_exclusive: %0d bad ready cycles required 0", viol - v0);
        end
    endtask

    task automatic test_basic();
        rec_t r;
        bit got;
        int t = cyc, c0 = clr_cnt, e0 = en_cnt;
        send(0, "begin end", 1, -1, 0, 0);
        wait_done(1, got);
        tests++;
        if (clr_cyc != t + 1 || ready_cyc != t + 2 || clr_cnt - c0 != 1) begin
            fails++;
            $display("FAIL basic_latency: clr at +%0d ready at +%0d clears %0d required +1 +2 1", clr_cyc - t, ready_cyc - t, clr_cnt - c0);
        end
        tests++;
        if (en_cnt - e0 != 9) begin
            fails++;
            $display("FAIL basic_chk_en: %0d pulses required 9", en_cnt - e0);
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL basic_done: no done required 1");
        end else begin
            r = dq.pop_front();
            tests++;
            if ({r.id[0], r.res, r.ovf, r.to} !== 4'b0100 || r.lat != 2 || r.fwd != "begin end") begin
                fails++;
                $display("FAIL basic_rec: id/res/ovf/to=%b%b%b%b lat=%0d fwd='%s' required 0100 2 'begin end'", r.id[0], r.res, r.ovf, r.to, r.lat, r.fwd);
            end
        end
        idle();
    endtask

    task automatic test_gap();
        rec_t r;
        bit got;
        send(1, "end begin", 1, 4, 5, 0);
        wait_done(1, got);
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL gap_done: no done required 1");
        end else begin
            r = dq.pop_front();
            if ({r.id[0], r.res, r.ovf, r.to} !== 4'b1000 || r.lat != 2 || r.fwd != "end begin") begin
                fails++;
                $display("FAIL gap_rec: id/res/ovf/to=%b%b%b%b lat=%0d fwd='%s' required 1000 2 'end begin'", r.id[0], r.res, r.ovf, r.to, r.lat, r.fwd);
            end
        end
        idle();
    endtask

    task automatic test_overflow();
        rec_t r;
        bit got;
        string s = "begin end ";
        int h;
        while (s.len() < 64) s = {s, "x"};
        for (int k = 0; k < 2; k++) begin
            h = hs_cnt[0];
            send(0, s, k == 1, -1, 0, k == 0 ? 2 : 0);
            wait_done(1, got);
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL ovf_done case=%0d: no done required 1", k);
            end else begin
                r = dq.pop_front();
                if ({r.ovf, r.res, r.to} !== {k == 0, k == 1, 1'b0} || r.fwd != s || hs_cnt[0] - h != 64) begin
                    fails++;
                    $display("FAIL ovf_rec case=%0d: ovf/res/to=%b%b%b accepted=%0d fwdlen=%0d required %0d%0d0 64 64", k, r.ovf, r.res, r.to, hs_cnt[0] - h, r.fwd.len(), k == 0, k == 1);
                end
            end
            idle();
        end
    endtask

    task automatic test_reset_mid();
        rec_t r;
        bit got;
        int c0;
        send(0, "beg", 0, -1, 0, 0);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || grant !== 2'b01) begin
            fails++;
            $display("FAIL rstmid_pre: busy=%b grant=%b required 1 01", busy, grant);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({req0_ready, req1_ready, chk_clr, chk_en, chk_char, grant, busy, done, done_id, done_result, overflow, timeout} !== 20'h0) begin
            fails++;
            $display("FAIL rstmid_outputs: got %h required 0", {req0_ready, req1_ready, chk_clr, chk_en, chk_char, grant, busy, done, done_id, done_result, overflow, timeout});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (dq.size() != 0) begin
            fails++;
            $display("FAIL rstmid_nodone: %0d dones required 0", dq.size());
            dq.delete();
        end
        c0 = clr_cnt;
        send(0, "begin end", 1, -1, 0, 0);
        wait_done(1, got);
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL rstmid_done: no done required 1");
        end else begin
            r = dq.pop_front();
            if (clr_cnt - c0 != 1 || r.fwd != "begin end" || r.res !== 1'b1) begin
                fails++;
                $display("FAIL rstmid_next: clears=%0d fwd='%s' res=%b required 1 'begin end' 1", clr_cnt - c0, r.fwd, r.res);
            end
        end
        idle();
    endtask

    task automatic test_stall();
        rec_t r;
        bit got;
`ifdef SENT_IDLE_TIMEOUT_EN
        int l;
        send(0, "beg", 0, -1, 0, 0);
        repeat (15) @(posedge clk);
        #1;
        send(0, "in end", 1, -1, 0, 0);
        wait_done(1, got);
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL stall15_done: no done required 1");
        end else begin
            r = dq.pop_front();
            if ({r.res, r.ovf, r.to} !== 3'b100 || r.fwd != "begin end") begin
                fails++;
                $display("FAIL stall15_rec: res/ovf/to=%b%b%b fwd='%s' required 100 'begin end'", r.res, r.ovf, r.to, r.fwd);
            end
        end
        idle();
        send(0, "beg", 0, -1, 0, 0);
        l = hs_cyc[0];
        wait_done(1, got);
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL stall16_done: no done required 1");
        end else begin
            r = dq.pop_front();
            if ({r.res, r.ovf, r.to} !== 3'b001 || r.fwd != "beg" || r.lat != 18) begin
                fails++;
                $display("FAIL stall16_rec: res/ovf/to=%b%b%b fwd='%s' lat=%0d (from hs %0d) required 001 'beg' 18", r.res, r.ovf, r.to, r.fwd, r.lat, l);
            end
        end
`else
        send(0, "beg", 0, -1, 0, 0);
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if (dq.size() != 0 || busy !== 1'b1 || req0_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_wait: dones=%0d busy=%b ready=%b required 0 1 1", dq.size(), busy, req0_ready);
        end
        send(0, "in end", 1, -1, 0, 0);
        wait_done(1, got);
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL stall_done: no done required 1");
        end else begin
            r = dq.pop_front();
            if ({r.res, r.ovf, r.to} !== 3'b100 || r.fwd != "begin end") begin
                fails++;
                $display("FAIL stall_rec: res/ovf/to=%b%b%b fwd='%s' required 100 'begin end'", r.res, r.ovf, r.to, r.fwd);
            end
        end
`endif
        idle();
    endtask

    task automatic test_random();
        rec_t r;
        bit got;
        for (int k = 0; k < 20; k++) begin
            int id = $urandom_range(0, 1);
            string s = rand_sentence();
            int ga = (s.len() < 2 || $urandom_range(0, 2) == 0) ? -1 : $urandom_range(1, s.len() - 1);
            int gl = $urandom_range(0, 6);
            send(id, s, 1, ga, gl, 0);
            wait_done(1, got);
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL rand_done k=%0d: no done required 1", k);
            end else begin
                r = dq.pop_front();
                if ({r.id[0], r.res, r.ovf, r.to} !== {id[0], bal(s), 2'b00} || r.fwd != s || r.lat != 2) begin
                    fails++;
                    $display("FAIL rand_rec k=%0d: id/res/ovf/to=%b%b%b%b fwd='%s' lat=%0d required %0d%0d00 '%s' 2", k, r.id[0], r.res, r.ovf, r.to, r.fwd, r.lat, id, bal(s), s);
                end
            end
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_basic();
        test_gap();
        test_overflow();
        test_reset_mid();
        test_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
